// File: rtl/uart_intr_if.sv
// Signal bundle between the UART register block and the interrupt controller.
// The register block is the master and the interrupt controller is the slave.
interface uart_intr_if #(
   parameter int FIFO_AW = 4
);
   logic               erbi, etbei, elsi;
   logic               oe, pe, fe, bi;
   logic               dr, thre, fifoen;
   logic [1:0]         rxfiftl;
   logic [FIFO_AW:0]   rx_fifo_cnt;
   logic               receive_done, bit_tick;
   logic               rbr_rd_en, thr_wr_en, iir_rd_en;
   logic               uart_intpt;
   logic               ipend_n;
   logic [2:0]         intid;

   modport master (
      output erbi, etbei, elsi, oe, pe, fe, bi, dr, thre, fifoen, rxfiftl,
             rx_fifo_cnt, receive_done, bit_tick, rbr_rd_en, thr_wr_en, iir_rd_en,
      input  uart_intpt, ipend_n, intid
   );

   modport slave (
      input  erbi, etbei, elsi, oe, pe, fe, bi, dr, thre, fifoen, rxfiftl,
             rx_fifo_cnt, receive_done, bit_tick, rbr_rd_en, thr_wr_en, iir_rd_en,
      output uart_intpt, ipend_n, intid
   );
endinterface

// File: rtl/uart_intr_ctrl.sv
// UART interrupt controller: prioritizes LSI > RDA > CTI > THRI into a single
// registered CPU interrupt plus the IIR interrupt ID.
module uart_intr_ctrl #(
   parameter int TOUT_BITS = 40,
   parameter int FIFO_AW   = 4
) (
   input  logic       pclk,
   input  logic       preset,
   uart_intr_if.slave bus
);
   localparam int TW = $clog2(TOUT_BITS + 1);
   localparam logic [TW-1:0] TMAX = TW'(TOUT_BITS);

   localparam logic [2:0] ID_LSI  = 3'b011;
   localparam logic [2:0] ID_RDA  = 3'b010;
   localparam logic [2:0] ID_CTI  = 3'b110;
   localparam logic [2:0] ID_THRI = 3'b001;
   localparam logic [2:0] ID_NONE = 3'b000;

   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic             cti_flag_q, cti_flag_d;
   logic             thre_pend_q, thre_pend_d;
   logic             thre_q, etbei_q;
   logic             intpt_q, intpt_d;
   logic [2:0]       intid_q, intid_d;
   logic [FIFO_AW:0] trig;
   logic             lsi, rda, cti, thri;
   logic             tclr, thre_set, iir_clr;

   always_comb begin
      trig = (FIFO_AW+1)'(1);
      case (bus.rxfiftl)
         2'b00:   trig = (FIFO_AW+1)'(1);
         2'b01:   trig = (FIFO_AW+1)'(4);
         2'b10:   trig = (FIFO_AW+1)'(8);
         default: trig = (FIFO_AW+1)'(14);
      endcase
   end

   assign lsi  = bus.elsi & (bus.oe | bus.pe | bus.fe | bus.bi);
   assign rda  = bus.erbi & (bus.fifoen ? (bus.rx_fifo_cnt >= trig) : bus.dr);
   assign cti  = bus.erbi & bus.fifoen & cti_flag_q;
   assign thri = bus.etbei & thre_pend_q;

   // Any sign of RX activity (or an empty/disabled FIFO) restarts the timeout.
   assign tclr = bus.receive_done | bus.rbr_rd_en | ~bus.fifoen | (bus.rx_fifo_cnt == '0);

   always_comb begin
      tcnt_d = tcnt_q;
      if (tclr)
         tcnt_d = '0;
      else if (bus.bit_tick && (tcnt_q != TMAX))
         tcnt_d = tcnt_q + 1'b1;
   end

   assign cti_flag_d = ~tclr & (tcnt_d == TMAX);

   assign thre_set = (bus.thre & ~thre_q) | (bus.etbei & ~etbei_q & bus.thre);
   assign iir_clr  = bus.iir_rd_en & (intid_q == ID_THRI);

   // A THR write beats a new edge; a new edge beats the IIR-read clear.
   always_comb begin
      thre_pend_d = thre_pend_q;
      if (bus.thr_wr_en)
         thre_pend_d = 1'b0;
      else if (thre_set)
         thre_pend_d = 1'b1;
      else if (iir_clr)
         thre_pend_d = 1'b0;
   end

   always_comb begin
      intid_d = ID_NONE;
      if (lsi)       intid_d = ID_LSI;
      else if (rda)  intid_d = ID_RDA;
      else if (cti)  intid_d = ID_CTI;
      else if (thri) intid_d = ID_THRI;
      intpt_d = lsi | rda | cti | thri;
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         tcnt_q      <= '0;
         cti_flag_q  <= 1'b0;
         thre_pend_q <= 1'b0;
         thre_q      <= 1'b0;
         etbei_q     <= 1'b0;
         intpt_q     <= 1'b0;
         intid_q     <= ID_NONE;
      end else begin
         tcnt_q      <= tcnt_d;
         cti_flag_q  <= cti_flag_d;
         thre_pend_q <= thre_pend_d;
         thre_q      <= bus.thre;
         etbei_q     <= bus.etbei;
         intpt_q     <= intpt_d;
         intid_q     <= intid_d;
      end
   end

   assign bus.uart_intpt = intpt_q;
   assign bus.ipend_n    = ~intpt_q;
   assign bus.intid      = intid_q;
endmodule

// File: tb/tb_uart_intr_ctrl.sv
// Bench for uart_intr_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_uart_intr_ctrl;
   localparam int TOUT = 40;

   logic pclk = 1'b0;
   logic preset;
   int   n_pass = 0;
   int   n_total = 0;

   uart_intr_if #(.FIFO_AW(4)) bus ();

   uart_intr_ctrl #(.TOUT_BITS(TOUT), .FIFO_AW(4)) dut (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   // Behavioural model: timeout is "bit ticks seen since RX activity", CTI is
   // simply that count having hit the threshold.
   int       m_tcnt;
   bit       m_pend, m_thre_q, m_etbei_q;
   bit       e_intpt;
   bit [2:0] e_id;
   int       m_trig;
   bit       m_lsi, m_rda, m_cti, m_thri, m_set, m_clr;

   always @(posedge pclk or posedge preset) begin
      if (preset) begin
         m_tcnt = 0; m_pend = 0; m_thre_q = 0; m_etbei_q = 0;
         e_intpt = 0; e_id = 0;
      end else begin
         m_trig = (bus.rxfiftl == 2'd0) ? 1 : (bus.rxfiftl == 2'd1) ? 4 :
                  (bus.rxfiftl == 2'd2) ? 8 : 14;
         m_lsi  = bus.elsi && (bus.oe || bus.pe || bus.fe || bus.bi);
         m_rda  = bus.erbi && (bus.fifoen ? (int'(bus.rx_fifo_cnt) >= m_trig) : bus.dr);
         m_cti  = bus.erbi && bus.fifoen && (m_tcnt >= TOUT);
         m_thri = bus.etbei && m_pend;
         m_set  = (bus.thre && !m_thre_q) || (bus.etbei && !m_etbei_q && bus.thre);
         if (bus.thr_wr_en) m_pend = 0;
         else if (m_set) m_pend = 1;
         else if (bus.iir_rd_en && e_id == 3'd1) m_pend = 0;
         e_id = m_lsi ? 3'd3 : m_rda ? 3'd2 : m_cti ? 3'd6 : m_thri ? 3'd1 : 3'd0;
         e_intpt = m_lsi || m_rda || m_cti || m_thri;
         m_clr = bus.receive_done || bus.rbr_rd_en || !bus.fifoen || bus.rx_fifo_cnt == 0;
         if (m_clr) m_tcnt = 0;
         else if (bus.bit_tick && m_tcnt < TOUT) m_tcnt = m_tcnt + 1;
         m_thre_q = bus.thre;
         m_etbei_q = bus.etbei;
      end
   end

   always @(negedge pclk) begin
      if (!preset) begin
         check("model_intpt", 32'(bus.uart_intpt), 32'(e_intpt));
         check("model_ipend_n", 32'(bus.ipend_n), 32'(!e_intpt));
         check("model_intid", 32'(bus.intid), 32'(e_id));
      end
   end

   initial begin
      preset = 1'b1;
      {bus.erbi, bus.etbei, bus.elsi, bus.oe, bus.pe, bus.fe, bus.bi} = '0;
      {bus.dr, bus.thre, bus.fifoen, bus.rxfiftl} = '0;
      bus.rx_fifo_cnt = '0;
      {bus.receive_done, bus.bit_tick, bus.rbr_rd_en, bus.thr_wr_en, bus.iir_rd_en} = '0;
      repeat (3) @(posedge pclk);
      #1;
      check("rst_intpt", 32'(bus.uart_intpt), 0);
      check("rst_ipend_n", 32'(bus.ipend_n), 1);
      check("rst_intid", 32'(bus.intid), 0);
      preset = 1'b0;

      // THRE edge raises THRI; IIR read clears it two cycles later
      bus.etbei = 1; step(2);
      check("thri_idle", 32'(bus.uart_intpt), 0);
      bus.thre = 1; step(1);
      check("thri_lat1", 32'(bus.uart_intpt), 0);
      step(1);
      check("thri_id", 32'(bus.intid), 3'b001);
      check("thri_intpt", 32'(bus.uart_intpt), 1);
      check("thri_ipend_n", 32'(bus.ipend_n), 0);
      bus.iir_rd_en = 1; step(1); bus.iir_rd_en = 0;
      check("iir_rd_n1", 32'(bus.uart_intpt), 1);
      step(1);
      check("iir_rd_n2", 32'(bus.uart_intpt), 0);

      // RX trigger level 4
      bus.etbei = 0; bus.fifoen = 1; bus.rxfiftl = 2'b01; bus.erbi = 1;
      for (int c = 0; c <= 4; c++) begin
         bus.rx_fifo_cnt = 5'(c); step(1);
         check($sformatf("rda_cnt%0d", c), 32'(bus.intid), (c == 4) ? 3'b010 : 3'b000);
      end
      bus.rx_fifo_cnt = 3; bus.rbr_rd_en = 1; step(1); bus.rbr_rd_en = 0;
      check("rda_drop", 32'(bus.intid), 3'b000);

      // character timeout after 40 bit ticks
      bus.thre = 0; bus.rxfiftl = 2'b10; bus.rx_fifo_cnt = 2;
      repeat (TOUT) begin bus.bit_tick = 1; step(1); end
      bus.bit_tick = 0;
      check("cti_pre", 32'(bus.intid), 3'b000);
      step(1);
      check("cti_id", 32'(bus.intid), 3'b110);

      // asynchronous reset mid-operation
      #1 preset = 1'b1;
      #1;
      check("prst_intpt", 32'(bus.uart_intpt), 0);
      check("prst_intid", 32'(bus.intid), 0);
      check("prst_tcnt", 32'(dut.tcnt_q), 0);
      step(1);
      preset = 1'b0;
      step(1);
      check("post_rst_id", 32'(bus.intid), 3'b000);

      // receive_done on the final tick suppresses the timeout
      repeat (TOUT - 1) begin bus.bit_tick = 1; step(1); end
      bus.receive_done = 1; step(1); bus.receive_done = 0;
      repeat (5) step(1);
      bus.bit_tick = 0; step(1);
      check("cti_suppressed", 32'(bus.intid), 3'b000);
      bus.rx_fifo_cnt = 0;

      // priority: LSI > RDA > THRI
      bus.etbei = 1; bus.thre = 1; bus.rxfiftl = 2'b01; bus.rx_fifo_cnt = 4;
      step(3);
      check("prio_rda", 32'(bus.intid), 3'b010);
      bus.elsi = 1; bus.pe = 1; step(1);
      check("prio_lsi", 32'(bus.intid), 3'b011);
      bus.pe = 0; step(1);
      check("prio_rda2", 32'(bus.intid), 3'b010);
      bus.rx_fifo_cnt = 0; step(1);
      check("prio_thri", 32'(bus.intid), 3'b001);

      // THR write coincident with a THRE rising edge wins
      bus.iir_rd_en = 1; step(1); bus.iir_rd_en = 0; step(2);
      check("thri_cleared", 32'(bus.uart_intpt), 0);
      bus.thre = 0; step(1);
      bus.thre = 1; bus.thr_wr_en = 1; step(1); bus.thr_wr_en = 0;
      step(2);
      check("wr_wins_intpt", 32'(bus.uart_intpt), 0);
      check("wr_wins_pend", 32'(dut.thre_pend_q), 0);

      // randomized traffic
      for (int seg = 0; seg < 40; seg++) begin
         bus.rx_fifo_cnt = 5'($urandom_range(0, 16));
         bus.fifoen  = ($urandom_range(0, 9) < 8);
         bus.rxfiftl = 2'($urandom_range(0, 3));
         bus.erbi    = ($urandom_range(0, 9) < 7);
         bus.elsi    = ($urandom_range(0, 9) < 7);
         bus.etbei   = ($urandom_range(0, 9) < 7);
         repeat (50) begin
            bus.bit_tick     = 1'($urandom_range(0, 1));
            bus.receive_done = ($urandom_range(0, 39) == 0);
            bus.rbr_rd_en    = ($urandom_range(0, 29) == 0);
            bus.thr_wr_en    = ($urandom_range(0, 7) == 0);
            bus.iir_rd_en    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0) bus.thre = ~bus.thre;
            if ($urandom_range(0, 14) == 0) bus.etbei = ~bus.etbei;
            if ($urandom_range(0, 9) == 0) bus.dr = ~bus.dr;
            bus.oe = ($urandom_range(0, 19) == 0);
            bus.pe = ($urandom_range(0, 19) == 0);
            bus.fe = ($urandom_range(0, 19) == 0);
            bus.bi = ($urandom_range(0, 19) == 0);
            step(1);
         end
      end
      {bus.receive_done, bus.bit_tick, bus.rbr_rd_en, bus.thr_wr_en, bus.iir_rd_en} = '0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
